// File: rtl/asteroid_border_if.sv
// Collision/escape interface between the asteroid mover side and
// asteroid_border_monitor.
//
// Handshake: startOfFrame is a valid-only strobe. It is high for a single
// cycle and there is no ready. topLeftX, topLeftY and asteroidIsHit are
// sampled on that edge. asteroidIsHit is a level and is also observed on
// every other cycle. border_collision and escape_pulse are valid-only
// one-cycle strobes back to the mover. HitEdgeCode, escape_count and
// dbg_state are levels.
//
// Signals:
//   startOfFrame     mover -> monitor  one-cycle frame strobe
//   topLeftX/Y       mover -> monitor  signed asteroid top-left position
//   asteroidIsHit    mover -> monitor  asteroid destroyed (level)
//   border_collision monitor -> mover  one-cycle hit pulse
//   HitEdgeCode      monitor -> mover  [3]=left [2]=top [1]=right [0]=bottom
//   escape_pulse     monitor -> score  one-cycle escape pulse
//   escape_count     monitor -> score  saturating escape count
//   dbg_state        monitor -> debug  current FSM state
interface asteroid_border_if #(
    parameter int PIXEL_WIDTH = 11,
    parameter int COUNT_WIDTH = 4
);
    logic                          startOfFrame;
    logic signed [PIXEL_WIDTH-1:0] topLeftX;
    logic signed [PIXEL_WIDTH-1:0] topLeftY;
    logic                          asteroidIsHit;
    logic                          border_collision;
    logic [3:0]                    HitEdgeCode;
    logic                          escape_pulse;
    logic [COUNT_WIDTH-1:0]        escape_count;
    logic [1:0]                    dbg_state;

    // Mover / environment side
    modport master (
        output startOfFrame, topLeftX, topLeftY, asteroidIsHit,
        input  border_collision, HitEdgeCode, escape_pulse, escape_count, dbg_state
    );

    // Monitor side
    modport slave (
        input  startOfFrame, topLeftX, topLeftY, asteroidIsHit,
        output border_collision, HitEdgeCode, escape_pulse, escape_count, dbg_state
    );
endinterface

// File: rtl/asteroid_border_monitor.sv
// asteroid_border_monitor: checks the asteroid position once per frame.
// It reports edge hits to the mover as a one-cycle border_collision pulse
// plus a HitEdgeCode. After each reported hit it ignores a number of
// frames so the mover can relocate the object. It also counts asteroids
// that leave past the right edge without being shot.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    asteroid_border_if.slave (frame strobe, position, hit level in;
//          collision pulse, edge code, escape pulse/count, debug state out)
module asteroid_border_monitor #(
    parameter int PIXEL_WIDTH     = 11,
    parameter int OBJ_WIDTH       = 32,
    parameter int OBJ_HEIGHT      = 32,
    parameter int LEFT_BORDER     = 0,
    parameter int RIGHT_BORDER    = 639,
    parameter int TOP_BORDER      = 0,
    parameter int BOTTOM_BORDER   = 479,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int COUNT_WIDTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    asteroid_border_if.slave  bus
);

    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        COOLDOWN = 2'd1,
        DEAD     = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   coll, coll_next;
    logic [3:0]             code, code_next;
    logic                   pulse, pulse_next;
    logic [COUNT_WIDTH-1:0] count, count_next;

    // Sign-extend the positions to 32 bits so the border arithmetic cannot
    // overflow the narrow coordinate width.
    logic signed [31:0] x_ext, y_ext;
    logic               f_left, f_right, f_top, f_bottom;
    logic [3:0]         flags;

    assign x_ext = {{(32-PIXEL_WIDTH){bus.topLeftX[PIXEL_WIDTH-1]}}, bus.topLeftX};
    assign y_ext = {{(32-PIXEL_WIDTH){bus.topLeftY[PIXEL_WIDTH-1]}}, bus.topLeftY};

    assign f_left   = x_ext < LEFT_BORDER;
    assign f_right  = (x_ext + OBJ_WIDTH - 1) > RIGHT_BORDER;
    assign f_top    = y_ext < TOP_BORDER;
    assign f_bottom = (y_ext + OBJ_HEIGHT - 1) > BOTTOM_BORDER;
    assign flags    = {f_left, f_top, f_right, f_bottom};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        coll_next  = 1'b0;           // pulses clear unless re-armed below
        pulse_next = 1'b0;
        code_next  = code;
        count_next = count;

        if (bus.asteroidIsHit) begin
            // A destroyed asteroid overrides any evaluation on the same edge.
            state_next = DEAD;
            code_next  = 4'b0000;
        end else begin
            unique case (state)
                ARMED: begin
                    if (bus.startOfFrame) begin
                        if (|flags) begin
                            code_next  = flags;
                            coll_next  = 1'b1;
                            cnt_next   = CW'(COOLDOWN_FRAMES);
                            state_next = COOLDOWN;
                            if (f_right) begin
                                pulse_next = 1'b1;
                                if (count != {COUNT_WIDTH{1'b1}}) begin
                                    count_next = count + 1'b1;
                                end
                            end
                        end else begin
                            code_next = 4'b0000;
                        end
                    end
                end
                COOLDOWN: begin
                    // HitEdgeCode holds. Re-arm once the last ignored frame
                    // has been consumed.
                    if (bus.startOfFrame) begin
                        cnt_next = cnt - 1'b1;
                        if (cnt <= CW'(1)) begin
                            state_next = ARMED;
                        end
                    end
                end
                DEAD: begin
                    code_next = 4'b0000;
                end
                default: begin
                    state_next = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARMED;
            cnt   <= '0;
            coll  <= 1'b0;
            code  <= 4'b0000;
            pulse <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            coll  <= coll_next;
            code  <= code_next;
            pulse <= pulse_next;
            count <= count_next;
        end
    end

    assign bus.border_collision = coll;
    assign bus.HitEdgeCode      = code;
    assign bus.escape_pulse     = pulse;
    assign bus.escape_count     = count;
    assign bus.dbg_state        = state;

endmodule

// File: tb/tb_asteroid_border_monitor.sv
// Self-checking bench for asteroid_border_monitor.
// The inputs are driven on falling edges and the DUT evaluates on the
// rising edge. Outputs are sampled on the following falling edge. A
// frame-level reference model keeps the number of ignored frames, the
// dead flag and the escape tally, and predicts each frame's outcome from
// the border rules.
module tb_asteroid_border_monitor;

    localparam int COOLDOWN = 2;
    localparam int CMAX     = 15;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    asteroid_border_if #(.PIXEL_WIDTH(11), .COUNT_WIDTH(4)) bus ();

    asteroid_border_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    bit   m_dead;
    int   m_block;
    logic [3:0] m_code;
    int   m_count;
    bit   exp_coll;
    bit   exp_pulse;

    logic [9:0] exp_q[$];   // {coll, code[3:0], pulse, count[3:0]}

    task automatic model_reset();
        m_dead  = 0;
        m_block = 0;
        m_code  = 4'b0000;
        m_count = 0;
    endtask

    task automatic model_frame(input int x, input int y, input bit hit);
        logic [3:0] f;
        exp_coll  = 0;
        exp_pulse = 0;
        f = {x < 0, y < 0, (x + 31) > 639, (y + 31) > 479};
        if (hit) m_dead = 1;
        if (m_dead) begin
            m_code = 4'b0000;
        end else if (m_block > 0) begin
            m_block = m_block - 1;
        end else if (f != 4'b0000) begin
            m_code   = f;
            exp_coll = 1;
            m_block  = COOLDOWN;
            if (f[1]) begin
                exp_pulse = 1;
                if (m_count < CMAX) m_count = m_count + 1;
            end
        end else begin
            m_code = 4'b0000;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.startOfFrame  = 1'b0;
        bus.asteroidIsHit = 1'b0;
        bus.topLeftX = 11'sd100;
        bus.topLeftY = 11'sd100;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Call this at a falling edge. It leaves the bench at the falling edge
    // just after the evaluating rising edge, so the outputs can be sampled.
    task automatic drive_frame(input int x, input int y, input bit hit);
        bus.topLeftX      = x[10:0];
        bus.topLeftY      = y[10:0];
        bus.asteroidIsHit = hit;
        bus.startOfFrame  = 1'b1;
        model_frame(x, y, hit);
        @(posedge clk);
        @(negedge clk);
        bus.startOfFrame  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.startOfFrame  = 1'b0;
        bus.asteroidIsHit = 1'b0;
        bus.topLeftX = 11'sd100;
        bus.topLeftY = 11'sd100;
        #1;
        n_checks++;
        if ({bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got coll=%b code=%b pulse=%b count=%0d, want all 0",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count);
        end
        n_checks++;
        if (bus.dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %0d want 0 (ARMED)", bus.dbg_state);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_interior();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_frame(100, 100, 0);
            n_checks++;
            if (bus.border_collision !== 1'b0 || bus.HitEdgeCode !== 4'b0000) begin
                n_errors++;
                $display("FAIL interior_frame%0d: got coll=%b code=%b want 0/0000",
                         i, bus.border_collision, bus.HitEdgeCode);
            end
            idle_cycle();
        end
    endtask

    task automatic test_right_escape();
        apply_reset();
        drive_frame(620, 100, 0);
        n_checks++;
        if (bus.border_collision !== 1'b1 || bus.HitEdgeCode !== 4'b0010 ||
            bus.escape_pulse !== 1'b1 || bus.escape_count !== 4'd1) begin
            n_errors++;
            $display("FAIL right_escape: got coll=%b code=%b pulse=%b count=%0d want 1/0010/1/1",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count);
        end
        idle_cycle();
        n_checks++;
        if (bus.border_collision !== 1'b0 || bus.escape_pulse !== 1'b0 ||
            bus.HitEdgeCode !== 4'b0010 || bus.escape_count !== 4'd1) begin
            n_errors++;
            $display("FAIL right_escape_clear: got coll=%b pulse=%b code=%b count=%0d want 0/0/0010/1",
                     bus.border_collision, bus.escape_pulse, bus.HitEdgeCode, bus.escape_count);
        end
    endtask

    task automatic test_cooldown();
        bit want[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_frame(620, 200, 0);
            n_checks++;
            if (bus.border_collision !== want[i] || bus.HitEdgeCode !== 4'b0010) begin
                n_errors++;
                $display("FAIL cooldown_frame%0d: got coll=%b code=%b want %b/0010",
                         i, bus.border_collision, bus.HitEdgeCode, want[i]);
            end
            idle_cycle();
            idle_cycle();
        end
        n_checks++;
        if (bus.escape_count !== 4'd2) begin
            n_errors++;
            $display("FAIL cooldown_count: got %0d want 2", bus.escape_count);
        end
    endtask

    task automatic test_corner();
        apply_reset();
        drive_frame(-5, 460, 0);
        n_checks++;
        if (bus.border_collision !== 1'b1 || bus.HitEdgeCode !== 4'b1001 ||
            bus.escape_pulse !== 1'b0 || bus.escape_count !== 4'd0) begin
            n_errors++;
            $display("FAIL corner_left_bottom: got coll=%b code=%b pulse=%b count=%0d want 1/1001/0/0",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int xs[4] = '{620, 100, 100, -10};
        apply_reset();
        // No idle cycles between frames, so each new strobe lands in the
        // cycle where the previous pulse is visible.
        for (int i = 0; i < 4; i++) begin
            drive_frame(xs[i], 100, 0);
            bus.startOfFrame = 1'b1;
            n_checks++;
            if (bus.border_collision !== exp_coll || bus.HitEdgeCode !== m_code ||
                bus.escape_pulse !== exp_pulse || bus.escape_count !== 4'(m_count)) begin
                n_errors++;
                $display("FAIL back_to_back%0d: got coll=%b code=%b pulse=%b count=%0d want %b/%b/%b/%0d",
                         i, bus.border_collision, bus.HitEdgeCode, bus.escape_pulse,
                         bus.escape_count, exp_coll, m_code, exp_pulse, m_count);
            end
        end
        bus.startOfFrame = 1'b0;
        idle_cycle();
    endtask

    task automatic test_random();
        logic [9:0] e;
        logic [9:0] got;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            int x = int'($urandom_range(760)) - 60;
            int y = int'($urandom_range(560)) - 60;
            int gap = int'($urandom_range(2));
            drive_frame(x, y, 0);
            exp_q.push_back({exp_coll, m_code, exp_pulse, 4'(m_count)});
            got = {bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL random%0d x=%0d y=%0d: got coll/code/pulse/count=%b want %b",
                         i, x, y, got, e);
            end
            for (int g = 0; g < gap; g++) idle_cycle();
        end
    endtask

    task automatic test_dead();
        apply_reset();
        // A hit on the evaluating edge wins over the right-edge escape.
        drive_frame(700, 100, 1);
        n_checks++;
        if (bus.border_collision !== 1'b0 || bus.HitEdgeCode !== 4'b0000 || bus.escape_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL dead_same_edge: got coll=%b code=%b pulse=%b want 0/0000/0",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            drive_frame(700, 100, 0);
            n_checks++;
            if (bus.border_collision !== 1'b0 || bus.HitEdgeCode !== 4'b0000 ||
                bus.escape_pulse !== 1'b0 || bus.escape_count !== 4'd0) begin
                n_errors++;
                $display("FAIL dead_frame%0d: got coll=%b code=%b pulse=%b count=%0d want 0/0000/0/0",
                         i, bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count);
            end
            idle_cycle();
        end
    endtask

    task automatic test_reset_cooldown();
        apply_reset();
        drive_frame(620, 100, 0);
        idle_cycle();
        drive_frame(620, 100, 0);      // first ignored frame, still cooling down
        // Asynchronous reset in the middle of a clock-low phase
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_mid_cooldown: got coll=%b code=%b pulse=%b count=%0d want all 0",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_pulse, bus.escape_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive_frame(700, 100, 0);
        n_checks++;
        if (bus.border_collision !== 1'b1 || bus.HitEdgeCode !== 4'b0010 || bus.escape_count !== 4'd1) begin
            n_errors++;
            $display("FAIL hit_after_reset: got coll=%b code=%b count=%0d want 1/0010/1",
                     bus.border_collision, bus.HitEdgeCode, bus.escape_count);
        end
        idle_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive_frame(620, 300, 0);
            n_checks++;
            if (bus.escape_pulse !== 1'b1 || bus.escape_count !== 4'((i + 1 > CMAX) ? CMAX : i + 1)) begin
                n_errors++;
                $display("FAIL saturate_escape%0d: got pulse=%b count=%0d want 1/%0d",
                         i, bus.escape_pulse, bus.escape_count, (i + 1 > CMAX) ? CMAX : i + 1);
            end
            // Two in-bounds frames use up the cooldown.
            drive_frame(100, 300, 0);
            drive_frame(100, 300, 0);
        end
        n_checks++;
        if (bus.escape_count !== 4'd15) begin
            n_errors++;
            $display("FAIL saturate_final: got %0d want 15", bus.escape_count);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        test_reset();
        test_interior();
        test_right_escape();
        test_cooldown();
        test_corner();
        test_back_to_back();
        test_random();
        test_dead();
        test_reset_cooldown();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/asteroid_border_monitor.md
Name: asteroid_border_monitor

Overview:
Monitors an asteroid's top-left position once per frame and generates the `border_collision` pulse and `HitEdgeCode` that `asteroids_move` consumes. It is the producer end of the mover's collision interface.
- Applies a per-frame cooldown so the mover has time to relocate the object before another hit is reported.
- Counts asteroids that escape off the right edge without being shot.
- Sits between the asteroid mover and the game-state/score logic.

Parameters:
PIXEL_WIDTH, 11, width of signed coordinate inputs
OBJ_WIDTH, 32, asteroid bitmap width in pixels
OBJ_HEIGHT, 32, asteroid bitmap height in pixels
LEFT_BORDER, 0, leftmost legal pixel column
RIGHT_BORDER, 639, rightmost legal pixel column
TOP_BORDER, 0, topmost legal pixel row
BOTTOM_BORDER, 479, bottommost legal pixel row
COOLDOWN_FRAMES, 2, frames ignored after a reported hit (minimum 1)
COUNT_WIDTH, 4, escape counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
topLeftX  in  PIXEL_WIDTH (signed)  asteroid top-left X
topLeftY  in  PIXEL_WIDTH (signed)  asteroid top-left Y
asteroidIsHit  in  1  asteroid destroyed (level, from mover)
border_collision  out  1  one-cycle hit pulse to mover
HitEdgeCode  out  4  [3]=left [2]=top [1]=right [0]=bottom
escape_pulse  out  1  one-cycle pulse when an asteroid escapes right
escape_count  out  COUNT_WIDTH  saturating count of escapes

Behaviour:
- Reset: all outputs are 0, state is ARMED, and the cooldown counter is 0. Reset applies immediately and asynchronously at any point, including mid-cooldown.
- Edge flags (combinational, all comparisons signed and sign-extended to 32 bits):
  - left = topLeftX < LEFT_BORDER
  - right = topLeftX + OBJ_WIDTH - 1 > RIGHT_BORDER
  - top = topLeftY < TOP_BORDER
  - bottom = topLeftY + OBJ_HEIGHT - 1 > BOTTOM_BORDER
  - Multiple flags may be set at once, e.g. a corner.
- Evaluation happens only on clock edges where startOfFrame=1. No other cycle changes state, except the pulse clear one cycle later.
- States:
  - ARMED: on evaluation, if any flag is set:
    - register the flags into HitEdgeCode;
    - assert border_collision for exactly the next cycle;
    - load the cooldown counter with COOLDOWN_FRAMES;
    - go to COOLDOWN.
    If no flag is set, HitEdgeCode is set to 0.
  - COOLDOWN: on each evaluation, decrement the counter. When it reaches 0, go to ARMED. No border_collision is asserted while in COOLDOWN, and HitEdgeCode holds its last value.
  - DEAD: entered from any state on the first cycle asteroidIsHit=1. In DEAD, border_collision=0, HitEdgeCode=0 and escape counting is off. DEAD exits only via reset.
- Latency: border_collision and HitEdgeCode become valid in the cycle after the startOfFrame edge. This keeps the pulse out of the mover's position-update cycle, so the mover's respawn assignment is not overwritten.
- Escape:
  - Condition: an ARMED evaluation reports right=1 while asteroidIsHit=0.
  - Response, in the same cycle as border_collision: escape_pulse=1 for one cycle and escape_count increments.
  - escape_count saturates at 2^COUNT_WIDTH-1 and does not wrap.
- Simultaneous events:
  - asteroidIsHit=1 on an evaluation edge: DEAD wins, and no collision or escape is reported.
  - startOfFrame=1 in the cycle border_collision is high: the pulse still clears and the new evaluation proceeds normally.

Test Plan:
- Position (100,100) for 5 frames: border_collision never asserts and HitEdgeCode=0000.
- topLeftX=620 (right edge at 651 > 639) at a frame: exactly one cycle after the startOfFrame edge, border_collision=1, HitEdgeCode=0010, escape_pulse=1, escape_count=1.
- Hold X=620 for 4 frames with COOLDOWN_FRAMES=2: a pulse occurs at frames 0 and 3 only, and escape_count=2.
- topLeftX=-5, topLeftY=460: HitEdgeCode=1001 (left+bottom) and escape_count is unchanged.
- asteroidIsHit=1, then X=700: no pulse ever, HitEdgeCode=0. Assert reset mid-COOLDOWN: all outputs are 0 on the same cycle, and the next hit is reported immediately.
- Force 16 escapes with COUNT_WIDTH=4: escape_count stays at 15 and escape_pulse still fires on each escape.
